// File: rtl/alu_pipe.sv
// Handshaked, registered ALU with an iterative shift-add multiplier.
// Single-cycle ops load the output register directly; MUL takes WIDTH cycles.
module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic [TAG_W-1:0] out_tag
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [SW-1:0]    r_cnt;
  logic [TAG_W-1:0] r_tag;

  logic             r_valid;
  logic [WIDTH-1:0] r_res;
  logic             r_z;
  logic             r_c;
  logic             r_v;
  logic [TAG_W-1:0] r_otag;

  logic             w_accept;
  logic             w_is_mul;
  logic             w_sub;
  logic [WIDTH-1:0] w_b_op;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_alu;
  logic             w_c;
  logic             w_v;
  logic [WIDTH-1:0] w_addend;
  logic [WIDTH-1:0] w_acc_nxt;
  logic             w_mul_done;

  assign in_ready  = (r_state == S_IDLE) && (!r_valid || out_ready);
  assign w_accept  = in_valid && in_ready;
  assign w_is_mul  = (alu_op == OP_MUL);

  // SUB is a + ~b + 1 so one adder serves both and yields the carry
  assign w_sub  = (alu_op == OP_SUB);
  assign w_b_op = w_sub ? ~b : b;
  assign w_sum  = {1'b0, a} + {1'b0, w_b_op} + {{WIDTH{1'b0}}, w_sub};

  assign w_addend   = r_b[r_cnt] ? (r_a << r_cnt) : '0;
  assign w_acc_nxt  = r_acc + w_addend;
  assign w_mul_done = (r_state == S_MUL) && (r_cnt == SW'(WIDTH - 1));

  // Single-cycle result and flag selection
  always_comb begin
    w_alu = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (alu_op)
      OP_AND: w_alu = a & b;
      OP_OR:  w_alu = a | b;
      OP_XOR: w_alu = a ^ b;
      OP_SLL: w_alu = a << b[SW-1:0];
      OP_ADD: begin
        w_alu = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (a[WIDTH-1] == b[WIDTH-1]) &&
                (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        w_alu = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (a[WIDTH-1] != b[WIDTH-1]) &&
                (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT: w_alu = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: w_alu = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state: MUL entered on accept, left after the last partial product
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && w_is_mul) w_state_nxt = S_MUL;
      S_MUL:   if (w_mul_done) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Multiplier operand latch and shift-add accumulation
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      r_tag <= '0;
    end else if (w_accept && w_is_mul) begin
      r_a   <= a;
      r_b   <= b;
      r_acc <= '0;
      r_cnt <= '0;
      r_tag <= in_tag;
    end else if (r_state == S_MUL) begin
      r_acc <= w_acc_nxt;
      r_cnt <= r_cnt + SW'(1);
    end
  end

  // Output register: load on new result, else drain on transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_res   <= '0;
      r_z     <= 1'b0;
      r_c     <= 1'b0;
      r_v     <= 1'b0;
      r_otag  <= '0;
    end else if (w_accept && !w_is_mul) begin
      r_valid <= 1'b1;
      r_res   <= w_alu;
      r_z     <= (w_alu == '0);
      r_c     <= w_c;
      r_v     <= w_v;
      r_otag  <= in_tag;
    end else if (w_mul_done) begin
      r_valid <= 1'b1;
      r_res   <= w_acc_nxt;
      r_z     <= (w_acc_nxt == '0);
      r_c     <= 1'b0;
      r_v     <= 1'b0;
      r_otag  <= r_tag;
    end else if (r_valid && out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign result    = r_res;
  assign flag_z    = r_z;
  assign flag_c    = r_c;
  assign flag_v    = r_v;
  assign out_tag   = r_otag;

endmodule
